alu_issuer: RTL and testbench
=============================

Name: alu_issuer

Overview:
Command front-end that drives the combinational ALU. It accepts ALU commands over a valid/ready handshake and reads operands from an internal register file. It then presents opcode and operands to the ALU, captures the ALU result and flags, and writes them back. It sits between the instruction decode/control path and the ALU, and owns the general-purpose registers and the zero/carry flag state.

Parameters:
WORD_SIZE, 64, datapath width; must match the ALU's WORD_SIZE.
REG_ADDR_BITS, 3, register index width; register file holds 2**REG_ADDR_BITS words.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  issuer can accept a command this cycle.
cmd_opcode  input  4  ALU opcode, passed to the ALU unchanged.
cmd_rd  input  REG_ADDR_BITS  destination register.
cmd_rs1  input  REG_ADDR_BITS  source register for ALU d1.
cmd_rs2  input  REG_ADDR_BITS  source register for ALU d2.
load_en  input  1  direct register write strobe.
load_addr  input  REG_ADDR_BITS  direct write address.
load_data  input  WORD_SIZE  direct write data.
dbg_addr  input  REG_ADDR_BITS  debug read address.
dbg_data  output  WORD_SIZE  combinational read of register dbg_addr.
alu_d1  output  WORD_SIZE  to ALU d1.
alu_d2  output  WORD_SIZE  to ALU d2.
alu_opcode  output  4  to ALU opcode.
alu_out  input  WORD_SIZE  from ALU out.
alu_iszero  input  1  from ALU iszero.
alu_iscarry  input  1  from ALU iscarry.
done  output  1  one-cycle pulse when a command completes.
result  output  WORD_SIZE  last completed result.
zero_flag  output  1  iszero of last completed command.
carry_flag  output  1  iscarry of last completed command.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state is IDLE;
  - all registers are 0;
  - operand latches are 0;
  - alu_opcode = 4'b1111;
  - result = 0; zero_flag = 0; carry_flag = 0; done = 0.
  - cmd_ready = 1 once reset deasserts.
- States are IDLE, EXEC and DONE.
  - IDLE: cmd_ready = 1. On an edge with cmd_valid=1, the command is accepted. Latch:
    - cmd_opcode and cmd_rd;
    - reg[cmd_rs1] into the op1 latch and reg[cmd_rs2] into the op2 latch.
    - Go to EXEC.
  - EXEC: cmd_ready = 0. Drive alu_d1 = op1, alu_d2 = op2, alu_opcode = latched opcode. At the end of the cycle:
    - capture alu_out into result, alu_iszero into zero_flag, alu_iscarry into carry_flag;
    - write alu_out into reg[rd];
    - go to DONE.
  - DONE: cmd_ready = 0, done = 1 for exactly this cycle. Go to IDLE unconditionally.
- Latency and throughput: for acceptance at edge N, the write-back occurs at edge N+1 and done is high in the cycle after edge N+1. At most one command per 3 cycles.
- Outside EXEC:
  - alu_opcode = 4'b1111, the ALU pass-through default;
  - alu_d1 and alu_d2 hold the last latched operands.
- Register 0 always reads 0. Writes to it from either write-back or load are discarded; result and flags still update on write-back.
- Operand capture at acceptance:
  - operands are read at acceptance, so a load to rs1/rs2 during EXEC does not affect the in-flight command;
  - a load on the same edge as acceptance is not visible to that command.
- Load port: active in every state.
  - If load and write-back hit the same address on the same edge, write-back wins.
  - If the addresses differ, both writes complete.
- dbg_data reflects writes from the following cycle onward; there is no bypass.
- cmd_* inputs are ignored when cmd_ready = 0. A held cmd_valid is accepted on the next IDLE edge.
- result and flags hold their values until the next write-back.
- Reset mid-command: the in-flight command is dropped, with no write-back and no done pulse.
- All arithmetic is performed by the ALU. This block performs no width extension and no truncation.

Test Plan:
1. Load r1 = 5, r2 = 3; issue opcode 0000, rd = 3, rs1 = 1, rs2 = 2 -> alu_opcode = 0000 with alu_d1 = 5 and alu_d2 = 3 during EXEC. done pulses 2 cycles after acceptance; r3 = 8, zero_flag = 0, carry_flag = 0.
2. Issue opcode 0001, rd = 4, rs1 = 1, rs2 = 1 (r1 = 5) -> r4 = 0, zero_flag = 1, carry_flag = 1.
3. Load r5 = 64'hFFFF_FFFF_FFFF_FFFF, r6 = 1; issue add, rd = 7 -> r7 = 0, result = 0, zero_flag = 1, carry_flag = 1.
4. Issue add, rd = 0, rs1 = 1, rs2 = 2 -> result = 8 and done pulses, but dbg_addr = 0 reads 0. A separate load_en to address 0 with data 64'h55 also reads back 0.
5. Hold cmd_valid high across two commands -> cmd_ready is low for 2 cycles between acceptances; the second command is accepted exactly 3 cycles after the first. A load to that command's rd on its write-back edge loses to the write-back.
6. Assert reset during EXEC -> no done pulse, rd unchanged (0 after reset), cmd_ready = 1 after release, and a fresh add (r1 = 2, r2 = 2) gives r3 = 4.

Source files
------------

// File: rtl/alu_issuer.sv
// alu_issuer: accepts ALU commands, reads operands from its register file, drives the ALU and writes back result and flags
module alu_issuer #(
  parameter int WORD_SIZE     = 64,
  parameter int REG_ADDR_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [REG_ADDR_BITS-1:0] cmd_rd,
  input  logic [REG_ADDR_BITS-1:0] cmd_rs1,
  input  logic [REG_ADDR_BITS-1:0] cmd_rs2,
  input  logic                     load_en,
  input  logic [REG_ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]     load_data,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]     dbg_data,
  output logic [WORD_SIZE-1:0]     alu_d1,
  output logic [WORD_SIZE-1:0]     alu_d2,
  output logic [3:0]               alu_opcode,
  input  logic [WORD_SIZE-1:0]     alu_out,
  input  logic                     alu_iszero,
  input  logic                     alu_iscarry,
  output logic                     done,
  output logic [WORD_SIZE-1:0]     result,
  output logic                     zero_flag,
  output logic                     carry_flag
);
  localparam int NREG = 2 ** REG_ADDR_BITS;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [WORD_SIZE-1:0] regs [NREG];
  logic [WORD_SIZE-1:0] op1, op2;
  logic [3:0] opc;
  logic [REG_ADDR_BITS-1:0] rd;
  logic accept;
  always_comb begin
    state_n    = IDLE;
    cmd_ready  = state == IDLE;
    accept     = cmd_ready && cmd_valid;
    done       = state == DONE;
    alu_opcode = state == EXEC ? opc : 4'b1111;
    state_n    = state == IDLE ? (cmd_valid ? EXEC : IDLE) : state == EXEC ? DONE : IDLE;
  end
  assign alu_d1   = op1;
  assign alu_d2   = op2;
  assign dbg_data = regs[dbg_addr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op1        <= '0;
      op2        <= '0;
      opc        <= '0;
      rd         <= '0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        opc <= cmd_opcode;
        rd  <= cmd_rd;
        op1 <= regs[cmd_rs1];
        op2 <= regs[cmd_rs2];
      end
      if (load_en && load_addr != '0) regs[load_addr] <= load_data;
      if (state == EXEC) begin
        result     <= alu_out;
        zero_flag  <= alu_iszero;
        carry_flag <= alu_iscarry;
        if (rd != '0) regs[rd] <= alu_out;
      end
    end
  end
endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: directed stimulus with a cycle-level behavioural model and literal checks
module tb_alu_issuer;
  logic        clk = 1'b0, reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_opcode = '0;
  logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic        load_en = 1'b0;
  logic [2:0]  load_addr = '0, dbg_addr = '0;
  logic [63:0] load_data = '0;
  logic [63:0] dbg_data, alu_d1, alu_d2, alu_out, result;
  logic [3:0]  alu_opcode;
  logic        alu_iszero, alu_iscarry, done, zero_flag, carry_flag;
  int errors = 0, checks = 0;

  alu_issuer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_d1(alu_d1), .alu_d2(alu_d2),
    .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_iszero(alu_iszero),
    .alu_iscarry(alu_iscarry), .done(done), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] alu_f(logic [3:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b0001: return {1'b0, a} + {1'b0, ~b} + 65'd1;
      4'b0010: return {1'b0, a & b};
      4'b1111: return {1'b0, a};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_iscarry, alu_out} = alu_f(alu_opcode, alu_d1, alu_d2);
  assign alu_iszero = alu_out == 64'd0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  logic [63:0] m_regs [8];
  logic [63:0] m_op1, m_op2, m_res;
  logic [3:0]  m_opc;
  logic [2:0]  m_rd;
  logic        m_z, m_c;
  int          ec, acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_op1 = '0; m_op2 = '0; m_res = '0; m_opc = '0; m_rd = '0; m_z = 0; m_c = 0;
      ec = 0; acc = -10;
    end else begin
      int e;
      logic [64:0] r;
      logic wb;
      e  = ec + 1;
      wb = e - acc == 1;
      if (cmd_valid && e - acc >= 3) begin
        acc = e; m_opc = cmd_opcode; m_rd = cmd_rd;
        m_op1 = m_regs[cmd_rs1]; m_op2 = m_regs[cmd_rs2];
      end
      if (load_en && load_addr != 0) m_regs[load_addr] = load_data;
      if (wb) begin
        r = alu_f(m_opc, m_op1, m_op2);
        m_res = r[63:0]; m_c = r[64]; m_z = r[63:0] == 64'd0;
        if (m_rd != 0) m_regs[m_rd] = m_res;
      end
      ec = e;
    end
  end

  always @(negedge clk) begin
    chk("ready", cmd_ready, 64'(ec - acc >= 2));
    chk("done", done, 64'(ec - acc == 1));
    chk("alu_opcode", alu_opcode, ec == acc ? m_opc : 4'hf);
    chk("alu_d1", alu_d1, m_op1);
    chk("alu_d2", alu_d2, m_op2);
    chk("result", result, m_res);
    chk("zero_flag", zero_flag, m_z);
    chk("carry_flag", carry_flag, m_c);
    chk("dbg_data", dbg_data, m_regs[dbg_addr]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [2:0] a, logic [63:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic issue(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    int n;
    cmd_valid = 1; cmd_opcode = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    n = 0;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    chk("accept_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("exec_opcode", alu_opcode, op);
    chk("exec_done", done, 0);
    tick();
    chk("done_pulse", done, 1);
    tick();
    chk("done_clear", done, 0);
  endtask

  task automatic peek(string n, logic [2:0] a, logic [63:0] e);
    dbg_addr = a;
    #1;
    chk(n, dbg_data, e);
  endtask

  initial begin
    #2 reset = 1;
    tick(); tick();
    chk("rst_result", result, 0);
    chk("rst_opcode", alu_opcode, 4'hf);
    reset = 0;
    tick();
    chk("rst_ready", cmd_ready, 1);
    // 1: add
    load(1, 5); load(2, 3);
    issue(4'b0000, 3, 1, 2);
    peek("t1_r3", 3, 8);
    chk("t1_d1_hold", alu_d1, 5);
    chk("t1_d2_hold", alu_d2, 3);
    chk("t1_z", zero_flag, 0);
    chk("t1_c", carry_flag, 0);
    // 2: sub to zero
    issue(4'b0001, 4, 1, 1);
    peek("t2_r4", 4, 0);
    chk("t2_z", zero_flag, 1);
    chk("t2_c", carry_flag, 1);
    // 3: add overflow
    load(5, 64'hFFFF_FFFF_FFFF_FFFF); load(6, 1);
    issue(4'b0000, 7, 5, 6);
    peek("t3_r7", 7, 0);
    chk("t3_res", result, 0);
    chk("t3_z", zero_flag, 1);
    chk("t3_c", carry_flag, 1);
    // 4: register 0
    issue(4'b0000, 0, 1, 2);
    chk("t4_res", result, 8);
    peek("t4_r0", 0, 0);
    load(0, 64'h55);
    peek("t4_r0_load", 0, 0);
    // 5: held valid, back-to-back
    cmd_valid = 1; cmd_opcode = 4'b0000; cmd_rd = 5; cmd_rs1 = 1; cmd_rs2 = 2;
    tick();
    cmd_opcode = 4'b0001; cmd_rd = 6;
    chk("t5_rdy0", cmd_ready, 0);
    tick();
    chk("t5_rdy1", cmd_ready, 0);
    tick();
    chk("t5_rdy2", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("t5_second_exec", alu_opcode, 4'b0001);
    load_en = 1; load_addr = 6; load_data = 64'hDEAD;
    tick();
    load_en = 0;
    tick();
    peek("t5_r5", 5, 8);
    peek("t5_r6_wb_wins", 6, 2);
    // 6: reset mid-command
    issue(4'b0000, 3, 1, 2);
    cmd_valid = 1; cmd_opcode = 4'b0010; cmd_rd = 4; cmd_rs1 = 1; cmd_rs2 = 1;
    tick();
    cmd_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("t6_nodone", done, 0);
    chk("t6_ready", cmd_ready, 1);
    peek("t6_r4", 4, 0);
    tick();
    chk("t6_nodone2", done, 0);
    load(1, 2); load(2, 2);
    issue(4'b0000, 3, 1, 2);
    peek("t6_r3", 3, 4);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
